// File: rtl/pds_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pds_pkg
// Description : Shared definitions for the PDS power-allocation engine:
//               port count default, priority type, FSM state encoding and
//               power-bus width.
// Revision    : 1.0 - initial release
// ============================================================================
package pds_pkg;

   localparam int NUM_PORTS = 4;
   localparam int PWR_W     = 8;

   typedef logic [1:0] prio_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EVAL   = 2'd1,
      COMMIT = 2'd2
   } pds_state_e;

endpackage
`default_nettype wire

// File: rtl/pds_stagger_seq.sv
`default_nettype none
// ============================================================================
// Module      : pds_stagger_seq
// Description : Staggered turn-on sequencer. Holds the mask of granted ports
//               still waiting to power up and releases them lowest index
//               first: one at commit, then one every STAGGER_CYC cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pds_stagger_seq
   import pds_pkg::*;
#(
   parameter int numPorts    = NUM_PORTS,
   parameter int STAGGER_CYC = 8
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                commit,
   input  logic [numPorts-1:0] new_mask,
   input  logic [numPorts-1:0] off,
   input  logic                ports_off,
   output logic [numPorts-1:0] release_mask,
   output logic                pending
);

   localparam int CNT_W = $clog2(STAGGER_CYC + 1);
   localparam logic [CNT_W-1:0] C_RELOAD = CNT_W'(STAGGER_CYC);
   localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

   logic [numPorts-1:0] r_pend;
   logic [CNT_W-1:0]    r_cnt;
   logic [numPorts-1:0] w_live;
   logic [numPorts-1:0] w_first_new;
   logic [numPorts-1:0] w_first_live;

   // Isolate the lowest set bit of the new grants and of the live pending set
   always_comb begin
      w_live       = r_pend & ~off;
      w_first_new  = new_mask & (~new_mask + 1'b1);
      w_first_live = w_live & (~w_live + 1'b1);
      release_mask = '0;
      if (commit) begin
         release_mask = w_first_new;
      end else if (r_cnt == C_ONE) begin
         release_mask = w_first_live;
      end
   end

   assign pending = |r_pend;

   // Pending mask and inter-release countdown; a new commit replaces the mask
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend <= '0;
         r_cnt  <= '0;
      end else if (ports_off) begin
         r_pend <= '0;
         r_cnt  <= '0;
      end else if (commit) begin
         r_pend <= new_mask & ~w_first_new;
         r_cnt  <= C_RELOAD;
      end else begin
         r_pend <= w_live & ~release_mask;
         if (w_live != '0) begin
            r_cnt <= (r_cnt == C_ONE) ? C_RELOAD : r_cnt - 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/pds_port_alloc.sv
`default_nettype none
// ============================================================================
// Module      : pds_port_alloc
// Description : PDS power-allocation engine. Snapshots port controls, walks
//               every (priority level, port) slot once per pass granting
//               power while the budget allows, then commits the result to
//               the per-port on vector. Optional staggered turn-on is built
//               when the macro PDS_STAGGER_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module pds_port_alloc
   import pds_pkg::*;
#(
   parameter int numPorts    = NUM_PORTS,
   parameter int PORT_PWR    = 15,
   parameter int STAGGER_CYC = 8
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [numPorts-1:0]   det,
   input  logic [numPorts-1:0]   off,
   input  logic [2*numPorts-1:0] prio,
   input  logic [PWR_W-1:0]      pwr_bdj,
   input  logic                  ports_off,
   output logic [numPorts-1:0]   on,
   output logic [PWR_W-1:0]      pwr_used,
   output logic                  busy
);

   localparam int P_W = (numPorts > 1) ? $clog2(numPorts) : 1;
   localparam logic [P_W-1:0]   C_P_LAST  = P_W'(numPorts - 1);
   localparam logic [PWR_W:0]   C_PWR_INC = (PWR_W + 1)'(PORT_PWR);

   pds_state_e r_state;
   pds_state_e w_state_nxt;
   logic       w_capture;
   logic       w_commit;

   logic                  r_snap_vld;
   logic [numPorts-1:0]   r_snap_det;
   logic [numPorts-1:0]   r_snap_off;
   logic [2*numPorts-1:0] r_snap_prio;
   logic [PWR_W-1:0]      r_snap_pwr;

   logic [numPorts-1:0] r_grant;
   logic [PWR_W-1:0]    r_alloc;
   prio_t               r_lvl;
   logic [P_W-1:0]      r_p;

   logic                w_change;
   prio_t               w_sel_prio;
   logic                w_sel_det;
   logic                w_sel_off;
   logic                w_elig;
   logic [PWR_W:0]      w_sum;
   logic                w_fits;
   logic                w_last_slot;
   logic [numPorts-1:0] w_on_commit;
   logic [numPorts-1:0] w_on_hold;

   assign w_change = !r_snap_vld || (det != r_snap_det) || (off != r_snap_off) ||
                     (prio != r_snap_prio) || (pwr_bdj != r_snap_pwr);

   // Select the snapshot fields of the port addressed by the slot pointer
   always_comb begin
      w_sel_prio = '0;
      w_sel_det  = 1'b0;
      w_sel_off  = 1'b0;
      for (int i = 0; i < numPorts; i++) begin
         if (r_p == P_W'(i)) begin
            w_sel_prio = r_snap_prio[2*i +: 2];
            w_sel_det  = r_snap_det[i];
            w_sel_off  = r_snap_off[i];
         end
      end
   end

   // Budget test is one bit wider than the power bus so the sum cannot wrap
   assign w_elig      = (w_sel_prio == r_lvl) && w_sel_det && !w_sel_off;
   assign w_sum       = {1'b0, r_alloc} + C_PWR_INC;
   assign w_fits      = (w_sum <= {1'b0, r_snap_pwr});
   assign w_last_slot = (r_lvl == 2'd0) && (r_p == C_P_LAST);

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; global shutdown overrides every transition
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_change) begin
               w_state_nxt = EVAL;
               w_capture   = 1'b1;
            end
         end
         EVAL: begin
            if (w_last_slot) begin
               w_state_nxt = COMMIT;
            end
         end
         COMMIT: begin
            if (w_change) begin
               w_state_nxt = EVAL;
               w_capture   = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      if (ports_off) begin
         w_state_nxt = IDLE;
         w_capture   = 1'b0;
      end
   end

   assign w_commit = (r_state == COMMIT) && !ports_off;

   // Snapshot capture and the one-slot-per-cycle allocator walk
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_snap_vld  <= 1'b0;
         r_snap_det  <= '0;
         r_snap_off  <= '0;
         r_snap_prio <= '0;
         r_snap_pwr  <= '0;
         r_grant     <= '0;
         r_alloc     <= '0;
         r_lvl       <= 2'd3;
         r_p         <= '0;
      end else if (ports_off) begin
         r_snap_vld <= 1'b0;
      end else if (w_capture) begin
         r_snap_vld  <= 1'b1;
         r_snap_det  <= det;
         r_snap_off  <= off;
         r_snap_prio <= prio;
         r_snap_pwr  <= pwr_bdj;
         r_grant     <= '0;
         r_alloc     <= '0;
         r_lvl       <= 2'd3;
         r_p         <= '0;
      end else if (r_state == EVAL) begin
         if (w_elig && w_fits) begin
            r_grant[r_p] <= 1'b1;
            r_alloc      <= w_sum[PWR_W-1:0];
         end
         if (r_p == C_P_LAST) begin
            r_p   <= '0;
            r_lvl <= r_lvl - 2'd1;
         end else begin
            r_p <= r_p + 1'b1;
         end
      end
   end

`ifdef PDS_STAGGER_EN
   logic [numPorts-1:0] w_new;
   logic [numPorts-1:0] w_rel;
   logic                w_pend;

   // Ports granted this pass that are not yet powered go through the sequencer
   assign w_new = r_grant & ~on & ~off;

   pds_stagger_seq #(
      .numPorts    (numPorts),
      .STAGGER_CYC (STAGGER_CYC)
   ) u_stagger (
      .clk          (clk),
      .rst          (rst),
      .commit       (w_commit),
      .new_mask     (w_new),
      .off          (off),
      .ports_off    (ports_off),
      .release_mask (w_rel),
      .pending      (w_pend)
   );

   assign w_on_commit = (on & r_grant & ~off) | w_rel;
   assign w_on_hold   = (on | w_rel) & ~off;
   assign busy        = (r_state != IDLE) || w_pend;
`else
   // STAGGER_CYC only matters when the sequencer is built
   logic [31:0] w_unused_stagger_cyc;
   assign w_unused_stagger_cyc = STAGGER_CYC;

   assign w_on_commit = r_grant & ~off;
   assign w_on_hold   = on & ~off;
   assign busy        = (r_state != IDLE);
`endif

   // Output register: shutdown first, then commit, else apply per-port off
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         on       <= '0;
         pwr_used <= '0;
      end else if (ports_off) begin
         on       <= '0;
         pwr_used <= '0;
      end else if (w_commit) begin
         on       <= w_on_commit;
         pwr_used <= r_alloc;
      end else begin
         on <= w_on_hold;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pds_port_alloc.sv
`default_nettype none
// ============================================================================
// Module      : tb_pds_port_alloc
// Description : Directed self-checking bench for pds_port_alloc with four
//               ports, 15 units per port and stagger disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pds_port_alloc;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] det;
   logic [3:0] off;
   logic [7:0] prio;
   logic [7:0] pwr_bdj;
   logic       ports_off;
   logic [3:0] on;
   logic [7:0] pwr_used;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pds_port_alloc #(
      .numPorts    (4),
      .PORT_PWR    (15),
      .STAGGER_CYC (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .det       (det),
      .off       (off),
      .prio      (prio),
      .pwr_bdj   (pwr_bdj),
      .ports_off (ports_off),
      .on        (on),
      .pwr_used  (pwr_used),
      .busy      (busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and settle just after the last one
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst       = 1'b1;
      det       = 4'b1111;
      off       = 4'b0000;
      prio      = 8'h00;
      pwr_bdj   = 8'd60;
      ports_off = 1'b0;
      tick(2);
      check_eq("reset_on",   32'(on),       32'h0);
      check_eq("reset_pwr",  32'(pwr_used), 32'h0);
      check_eq("reset_busy", 32'(busy),     32'h0);

      // Full grant: first pass after reset; commit lands on the 18th edge
      rst = 1'b0;
      tick(17);
      check_eq("full_pre_on",   32'(on),   32'h0);
      check_eq("full_pre_busy", 32'(busy), 32'h1);
      tick(1);
      check_eq("full_on",  32'(on),       32'hF);
      check_eq("full_pwr", 32'(pwr_used), 32'd60);
      tick(1);
      check_eq("full_idle_busy", 32'(busy), 32'h0);

      // Reset asserted mid-pass clears outputs without waiting for an edge
      pwr_bdj = 8'd45;
      tick(5);
      check_eq("midpass_busy", 32'(busy), 32'h1);
      #2 rst = 1'b1;
      #1;
      check_eq("async_rst_on",   32'(on),       32'h0);
      check_eq("async_rst_pwr",  32'(pwr_used), 32'h0);
      check_eq("async_rst_busy", 32'(busy),     32'h0);
      tick(1);

      // Priority and tie-break: port3 first, then port0; port1 would exceed 40
      prio    = 8'b11_00_00_00;
      pwr_bdj = 8'd40;
      rst     = 1'b0;
      tick(17);
      check_eq("prio_pre_on", 32'(on), 32'h0);
      tick(1);
      check_eq("prio_on",  32'(on),       32'b1001);
      check_eq("prio_pwr", 32'(pwr_used), 32'd30);
      tick(2);

      // Per-port off: port3 drops at once, re-evaluation grants ports 0 and 1
      off = 4'b1000;
      tick(1);
      check_eq("portoff_fast_on", 32'(on),   32'b0001);
      check_eq("portoff_busy",    32'(busy), 32'h1);
      tick(16);
      check_eq("portoff_pre_on", 32'(on), 32'b0001);
      tick(1);
      check_eq("portoff_on",  32'(on),       32'b0011);
      check_eq("portoff_pwr", 32'(pwr_used), 32'd30);
      tick(2);

      // Global shutdown during EVAL, held for a few cycles, then released
      pwr_bdj = 8'd44;
      tick(4);
      check_eq("shut_eval_busy", 32'(busy), 32'h1);
      ports_off = 1'b1;
      tick(1);
      check_eq("shut_on",   32'(on),       32'h0);
      check_eq("shut_pwr",  32'(pwr_used), 32'h0);
      check_eq("shut_busy", 32'(busy),     32'h0);
      tick(2);
      check_eq("shut_hold_busy", 32'(busy), 32'h0);
      ports_off = 1'b0;
      tick(1);
      check_eq("release_busy", 32'(busy), 32'h1);
      tick(16);
      check_eq("release_pre_on", 32'(on), 32'h0);
      tick(1);
      check_eq("release_on",  32'(on),       32'b0011);
      check_eq("release_pwr", 32'(pwr_used), 32'd30);
      tick(2);

      // Budget boundary: 14 units fits nobody, 15 units fits exactly port0
      off     = 4'b0000;
      prio    = 8'h00;
      pwr_bdj = 8'd14;
      tick(17);
      check_eq("bdj14_pre_on", 32'(on), 32'b0011);
      tick(1);
      check_eq("bdj14_on",  32'(on),       32'h0);
      check_eq("bdj14_pwr", 32'(pwr_used), 32'h0);
      tick(2);
      pwr_bdj = 8'd15;
      tick(18);
      check_eq("bdj15_on",  32'(on),       32'b0001);
      check_eq("bdj15_pwr", 32'(pwr_used), 32'd15);
      tick(1);
      check_eq("bdj15_idle_busy", 32'(busy), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pds_port_alloc.md
# pds_port_alloc

Power-allocation engine for the PDS: the consuming end of the PDS port-control interface. It samples port detection, per-port disable, 2-bit port priorities, the global power budget and the global shutdown request. It then drives the per-port `on` vector. Ports are granted in priority order until the budget is exhausted, and the block re-evaluates whenever any control input changes.

## Interface
- `numPorts`, default 4: number of PSE ports.
- `PORT_PWR`, default 15: power units drawn by one powered port, 1..255.
- `STAGGER_CYC`, default 8: cycles between successive port turn-ons. Used only with `PDS_STAGGER_EN`.
- `clk` input 1: single clock, all state updates on posedge.
- `rst` input 1: asynchronous, active-high reset.
- `det` input numPorts: device detected on port i.
- `off` input numPorts: port i forced off.
- `prio` input 2*numPorts: priority of port i at `prio[2i+1:2i]`; 3 is highest.
- `pwr_bdj` input 8: total power budget in units.
- `ports_off` input 1: global shutdown request.
- `on` output numPorts: port i powered.
- `pwr_used` output 8: power units allocated by the last committed pass.
- `busy` output 1: evaluation pass in progress.

## Operation
- The FSM has three states: IDLE, EVAL and COMMIT.
- **IDLE**
  - Compare the live inputs {det, off, prio, pwr_bdj} with the stored snapshot.
  - On any difference: capture the snapshot, clear `alloc` and `grant`, set lvl=3 and p=0, and go to EVAL.
- **EVAL** processes one (lvl, p) slot per cycle.
  - A port is eligible when snap_prio[p]==lvl, snap_det[p]=1 and snap_off[p]=0.
  - If eligible and alloc+PORT_PWR ≤ snap_pwr_bdj (computed 9 bits wide, so no wrap), set grant[p] and add PORT_PWR to alloc.
  - Increment p. When p wraps, decrement lvl. After slot (0, numPorts-1), go to COMMIT.
  - Order is highest priority first; ties go to the lower index first.
  - Input changes during EVAL are ignored for the current pass.
- **COMMIT**
  - Set on ← grant & ~off_live and pwr_used ← alloc.
  - If the live inputs differ from the snapshot, go to EVAL with a new snapshot. Otherwise go to IDLE.
- **Per-port off**: off[i]=1 clears on[i] at the next edge in every state. This is independent of the FSM.
- **Global shutdown**: ports_off=1 has priority over everything else. At the next edge:
  - on=0, pwr_used=0 and the FSM goes to IDLE;
  - the snapshot is invalidated, so the first cycle after release starts a new pass;
  - while ports_off stays high, the FSM remains in IDLE.
- Reset values: on=0, pwr_used=0, busy=0, FSM=IDLE, snapshot invalid. The first cycle after reset therefore starts a pass.

## Timing
- busy=1 exactly while the FSM is in EVAL or COMMIT.
- Latency: with a change present before edge E0, `on` and `pwr_used` update at edge E0+4*numPorts+1. For numPorts=4 this is 17 cycles.
- Back-to-back passes add 4*numPorts+1 cycles each, with no IDLE gap.
- Forced-off latency (`off[i]` or `ports_off`) is one edge.
- Reset asserted mid-pass aborts immediately to reset values.

## Configuration
- `PDS_STAGGER_EN` defined:
  - COMMIT clears de-granted ports immediately and places newly granted ports in a pending mask.
  - The lowest-index pending port turns on at COMMIT, then one more every STAGGER_CYC cycles.
  - A new COMMIT replaces the pending mask. `off` and `ports_off` clear pending bits too.
  - busy stays high until the mask is empty.
- `PDS_STAGGER_EN` undefined: all granted ports turn on together at COMMIT. No stagger logic is built.

## Structure
- Package `pds_pkg` holds:
  - the `numPorts` default from the shared definitions;
  - the `prio_t` typedef (2-bit);
  - the `pds_state_e` enum {IDLE, EVAL, COMMIT};
  - the `PWR_W=8` constant.
- Sub-module `pds_stagger_seq` holds the pending mask and stagger counter, instantiated only under `PDS_STAGGER_EN`.
- The FSM, snapshot and allocator stay in the top module.

## Test plan
All scenarios use numPorts=4, PORT_PWR=15, stagger disabled.
- **Reset:** rst=1 mid-pass → on=0000, pwr_used=0 and busy=0 asynchronously.
- **Full grant:** det=1111, off=0000, prio all 0, pwr_bdj=60 → 17 cycles later on=1111, pwr_used=60.
- **Priority and tie-break:** det=1111, port3 prio=3, others prio=0, pwr_bdj=40 → on=1001, pwr_used=30.
- **Per-port off:** from on=1001, assert off[3] → on[3]=0 next edge, then on=0011 and pwr_used=30 after the re-evaluation.
- **Global shutdown:** ports_off pulse during EVAL → on=0000 next edge and busy=0. After release a new pass restores on=0011.
- **Budget boundary:** pwr_bdj=14 → on=0000, pwr_used=0. pwr_bdj=15 → on=0001.
